// File: rtl/memory_access_pkg.sv
// Shared pipeline definitions: opcode and funct3 encodings plus the
// memory-stage state type.
package memory_access_pkg;

  localparam int unsigned OPCODE_WIDTH = 7;

  // RV32I major opcodes shared by every pipeline stage
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_WIDTH-1:0] OP_OP     = 7'b0110011;
  localparam logic [OPCODE_WIDTH-1:0] OP_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_WIDTH-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = 7'b1100011;

  // funct3 sizes; stores reuse the encodings of the signed loads
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/memory_access_mem_align.sv
// Combinational lane logic for the memory stage.
// Ports:
//   funct_i       access size/sign (funct3)
//   off_i         byte offset within the word (addr[1:0])
//   store_data_i  raw store data from rs2
//   rdata_i       word returned by the bus
//   byte_en_o     lane enables for the access
//   wdata_o       store data replicated across lanes
//   load_data_o   selected and extended load result
//   misaligned_o  access does not fit its natural alignment
module memory_access_mem_align
  import memory_access_pkg::*;
#(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned FUNCT_WIDTH = 3
) (
  input  logic [FUNCT_WIDTH-1:0] funct_i,
  input  logic [1:0]             off_i,
  input  logic [DWIDTH-1:0]      store_data_i,
  input  logic [DWIDTH-1:0]      rdata_i,
  output logic [3:0]             byte_en_o,
  output logic [DWIDTH-1:0]      wdata_o,
  output logic [DWIDTH-1:0]      load_data_o,
  output logic                   misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{off_i, 3'b000} +: 8];
  assign half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Store lanes and alignment fault
  always_comb begin
    byte_en_o    = 4'b0000;
    wdata_o      = store_data_i;
    misaligned_o = 1'b0;
    case (funct_i)
      F3_LB, F3_LBU: begin
        byte_en_o = 4'b0001 << off_i;
        wdata_o   = {(DWIDTH/8){store_data_i[7:0]}};
      end
      F3_LH, F3_LHU: begin
        byte_en_o    = 4'b0011 << {off_i[1], 1'b0};
        wdata_o      = {(DWIDTH/16){store_data_i[15:0]}};
        misaligned_o = off_i[0];
      end
      F3_LW: begin
        byte_en_o    = 4'b1111;
        misaligned_o = (off_i != 2'b00);
      end
      default: ;
    endcase
  end

  // Load lane select and extension
  always_comb begin
    load_data_o = rdata_i;
    case (funct_i)
      F3_LB:   load_data_o = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data_o = {{(DWIDTH-8){1'b0}}, byte_sel};
      F3_LH:   load_data_o = {{(DWIDTH-16){half_sel[15]}}, half_sel};
      F3_LHU:  load_data_o = {{(DWIDTH-16){1'b0}}, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory stage: issues one bus transaction per LOAD/STORE, waits for ack,
// and forwards the instruction's passthrough fields to writeback.
// Ports:
//   me_clk/me_rst                clock, async active-high reset
//   me_i_*  (execute side)       opcode, funct, alu_value, rs2_data, rd, pc, ce/stall/flush
//   me_o_stb/wr_en/addr/wdata/byte_en, me_i_ack/rdata   data bus
//   me_o_* (writeback side)      data_load, rd passthrough, ce, misaligned
//   me_o_stall/me_o_flush        back-pressure and flush to execute
module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned AWIDTH      = 5,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned FUNCT_WIDTH = 3
) (
  input  logic                    me_clk,
  input  logic                    me_rst,
  input  logic [OPCODE_WIDTH-1:0] me_i_opcode,
  input  logic [FUNCT_WIDTH-1:0]  me_i_funct,
  input  logic [DWIDTH-1:0]       me_i_alu_value,
  input  logic [DWIDTH-1:0]       me_i_rs2_data,
  input  logic [AWIDTH-1:0]       me_i_rd_addr,
  input  logic                    me_i_we_rd,
  input  logic [PC_WIDTH-1:0]     me_i_pc,
  input  logic                    me_i_ce,
  input  logic                    me_i_stall,
  input  logic                    me_i_flush,
  output logic                    me_o_stb,
  output logic                    me_o_wr_en,
  output logic [DWIDTH-1:0]       me_o_addr,
  output logic [DWIDTH-1:0]       me_o_wdata,
  output logic [3:0]              me_o_byte_en,
  input  logic                    me_i_ack,
  input  logic [DWIDTH-1:0]       me_i_rdata,
  output logic [DWIDTH-1:0]       me_o_data_load,
  output logic [AWIDTH-1:0]       me_o_rd_addr,
  output logic [DWIDTH-1:0]       me_o_rd_data,
  output logic                    me_o_we_rd,
  output logic [OPCODE_WIDTH-1:0] me_o_opcode,
  output logic [FUNCT_WIDTH-1:0]  me_o_funct,
  output logic [PC_WIDTH-1:0]     me_o_pc,
  output logic                    me_o_ce,
  output logic                    me_o_stall,
  output logic                    me_o_flush,
  output logic                    me_o_misaligned
);

  state_e                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [FUNCT_WIDTH-1:0]  funct_q, funct_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [AWIDTH-1:0]       rd_addr_q, rd_addr_d;
  logic [DWIDTH-1:0]       rd_data_q, rd_data_d;
  logic                    we_rd_q, we_rd_d;
  logic                    ce_q, ce_d;
  logic                    stb_q, stb_d;
  logic                    wr_en_q, wr_en_d;
  logic [DWIDTH-1:0]       addr_q, addr_d;
  logic [DWIDTH-1:0]       wdata_q, wdata_d;
  logic [3:0]              byte_en_q, byte_en_d;
  logic [DWIDTH-1:0]       data_load_q, data_load_d;
  logic                    misaligned_q, misaligned_d;
  logic [1:0]              off_q, off_d;
  logic                    dead_q, dead_d;

  logic                    is_load, is_store, is_mem;
  logic [FUNCT_WIDTH-1:0]  align_funct;
  logic [1:0]              align_off;
  logic [3:0]              align_byte_en;
  logic [DWIDTH-1:0]       align_wdata;
  logic [DWIDTH-1:0]       align_load;
  logic                    align_mis;

  assign is_load  = (me_i_opcode == OP_LOAD);
  assign is_store = (me_i_opcode == OP_STORE);
  assign is_mem   = is_load | is_store;

  // One aligner serves both phases: incoming request in IDLE, held request in WAIT
  assign align_funct = (state_q == S_WAIT) ? funct_q : me_i_funct;
  assign align_off   = (state_q == S_WAIT) ? off_q   : me_i_alu_value[1:0];

  memory_access_mem_align #(
    .DWIDTH      (DWIDTH),
    .FUNCT_WIDTH (FUNCT_WIDTH)
  ) u_mem_align (
    .funct_i      (align_funct),
    .off_i        (align_off),
    .store_data_i (me_i_rs2_data),
    .rdata_i      (me_i_rdata),
    .byte_en_o    (align_byte_en),
    .wdata_o      (align_wdata),
    .load_data_o  (align_load),
    .misaligned_o (align_mis)
  );

  // State and stage registers
  always_ff @(posedge me_clk or posedge me_rst) begin
    if (me_rst) begin
      state_q      <= S_IDLE;
      opcode_q     <= '0;
      funct_q      <= '0;
      pc_q         <= '0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      we_rd_q      <= 1'b0;
      ce_q         <= 1'b0;
      stb_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      byte_en_q    <= '0;
      data_load_q  <= '0;
      misaligned_q <= 1'b0;
      off_q        <= '0;
      dead_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      funct_q      <= funct_d;
      pc_q         <= pc_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      we_rd_q      <= we_rd_d;
      ce_q         <= ce_d;
      stb_q        <= stb_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      byte_en_q    <= byte_en_d;
      data_load_q  <= data_load_d;
      misaligned_q <= misaligned_d;
      off_q        <= off_d;
      dead_q       <= dead_d;
    end
  end

  // Next-state and stage update
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    funct_d      = funct_q;
    pc_d         = pc_q;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    we_rd_d      = we_rd_q;
    ce_d         = ce_q;
    stb_d        = stb_q;
    wr_en_d      = wr_en_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    byte_en_d    = byte_en_q;
    data_load_d  = data_load_q;
    misaligned_d = misaligned_q;
    off_d        = off_q;
    dead_d       = dead_q;

    case (state_q)
      S_IDLE: begin
        if (me_i_flush) begin
          ce_d         = 1'b0;
          misaligned_d = 1'b0;
        end else if (!me_i_stall) begin
          ce_d         = 1'b0;
          misaligned_d = 1'b0;
          if (me_i_ce) begin
            opcode_d  = me_i_opcode;
            funct_d   = me_i_funct;
            pc_d      = me_i_pc;
            rd_addr_d = me_i_rd_addr;
            rd_data_d = me_i_alu_value;
            we_rd_d   = me_i_we_rd;
            off_d     = me_i_alu_value[1:0];
            if (!is_mem) begin
              ce_d    = 1'b1;
              wr_en_d = 1'b0;
            end else if (align_mis) begin
              // Faulting access never reaches the bus and must not retire a write
              ce_d         = 1'b1;
              misaligned_d = 1'b1;
              we_rd_d      = 1'b0;
              wr_en_d      = 1'b0;
            end else begin
              stb_d     = 1'b1;
              addr_d    = {me_i_alu_value[DWIDTH-1:2], 2'b00};
              wdata_d   = align_wdata;
              byte_en_d = align_byte_en;
              wr_en_d   = is_store;
              we_rd_d   = me_i_we_rd & ~is_store;
              dead_d    = 1'b0;
              state_d   = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        // A flush cannot abort the bus cycle; it only kills the result
        if (me_i_flush) dead_d = 1'b1;
        if (me_i_ack) begin
          stb_d   = 1'b0;
          state_d = S_IDLE;
          ce_d    = ~(dead_q | me_i_flush);
          if (dead_q | me_i_flush) we_rd_d = 1'b0;
          if (opcode_q == OP_LOAD) data_load_d = align_load;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign me_o_stb        = stb_q;
  assign me_o_wr_en      = wr_en_q;
  assign me_o_addr       = addr_q;
  assign me_o_wdata      = wdata_q;
  assign me_o_byte_en    = byte_en_q;
  assign me_o_data_load  = data_load_q;
  assign me_o_rd_addr    = rd_addr_q;
  assign me_o_rd_data    = rd_data_q;
  assign me_o_we_rd      = we_rd_q;
  assign me_o_opcode     = opcode_q;
  assign me_o_funct      = funct_q;
  assign me_o_pc         = pc_q;
  assign me_o_ce         = ce_q;
  assign me_o_misaligned = misaligned_q;
  // Pass-through controls are gated so reset drives every output low
  assign me_o_stall      = ~me_rst & (me_i_stall | (state_q == S_WAIT));
  assign me_o_flush      = ~me_rst & me_i_flush;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: vector table plus hand-written
// stall/flush/reset sequences.
module tb_memory_access;
  import memory_access_pkg::*;

  logic        clk, rst;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic [31:0] alu, rs2, pc, rdata;
  logic [4:0]  rd;
  logic        we_rd, ce, stall, flush, ack;

  logic        o_stb, o_wr_en, o_we_rd, o_ce, o_stall, o_flush, o_mis;
  logic [31:0] o_addr, o_wdata, o_load, o_rd_data, o_pc;
  logic [3:0]  o_be;
  logic [4:0]  o_rd_addr;
  logic [6:0]  o_opcode;
  logic [2:0]  o_funct;

  int errors = 0;
  int checks = 0;

  memory_access dut (
    .me_clk          (clk),
    .me_rst          (rst),
    .me_i_opcode     (opcode),
    .me_i_funct      (funct),
    .me_i_alu_value  (alu),
    .me_i_rs2_data   (rs2),
    .me_i_rd_addr    (rd),
    .me_i_we_rd      (we_rd),
    .me_i_pc         (pc),
    .me_i_ce         (ce),
    .me_i_stall      (stall),
    .me_i_flush      (flush),
    .me_o_stb        (o_stb),
    .me_o_wr_en      (o_wr_en),
    .me_o_addr       (o_addr),
    .me_o_wdata      (o_wdata),
    .me_o_byte_en    (o_be),
    .me_i_ack        (ack),
    .me_i_rdata      (rdata),
    .me_o_data_load  (o_load),
    .me_o_rd_addr    (o_rd_addr),
    .me_o_rd_data    (o_rd_data),
    .me_o_we_rd      (o_we_rd),
    .me_o_opcode     (o_opcode),
    .me_o_funct      (o_funct),
    .me_o_pc         (o_pc),
    .me_o_ce         (o_ce),
    .me_o_stall      (o_stall),
    .me_o_flush      (o_flush),
    .me_o_misaligned (o_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          ack_after;
    int          exp_stb;
    logic        exp_mis;
    logic        exp_we;
    logic        exp_wr;
    logic        chk_bus;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        chk_load;
    logic [31:0] exp_load;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  stb_n;
    bit  done;
    logic [31:0] exp_pc;
    exp_pc = 32'h1000 + 32'(idx * 4);
    @(negedge clk);
    opcode = v.opcode; funct = v.funct; alu = v.alu; rs2 = v.rs2;
    rd = v.rd; we_rd = 1'b1; pc = exp_pc; ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    stb_n = 0;
    done  = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (o_ce || o_mis) begin
        done = 1'b1;
      end else begin
        if (o_stb) begin
          stb_n++;
          chk($sformatf("v%0d_addr", idx), o_addr, v.exp_addr);
          chk($sformatf("v%0d_wr_en", idx), 32'(o_wr_en), 32'(v.exp_wr));
          chk($sformatf("v%0d_stall_wait", idx), 32'(o_stall), 32'd1);
          if (v.chk_bus) begin
            chk($sformatf("v%0d_byte_en", idx), 32'(o_be), 32'(v.exp_be));
            chk($sformatf("v%0d_wdata", idx), o_wdata, v.exp_wdata);
          end
          if (stb_n >= v.ack_after) begin
            ack = 1'b1;
            rdata = v.rdata;
          end
        end
        @(negedge clk);
        ack = 1'b0;
        rdata = '0;
      end
    end
    chk($sformatf("v%0d_done_in_budget", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d_stb_cycles", idx), 32'(stb_n), 32'(v.exp_stb));
    chk($sformatf("v%0d_stb_low", idx), 32'(o_stb), 32'd0);
    chk($sformatf("v%0d_ce", idx), 32'(o_ce), 32'd1);
    chk($sformatf("v%0d_misaligned", idx), 32'(o_mis), 32'(v.exp_mis));
    chk($sformatf("v%0d_we_rd", idx), 32'(o_we_rd), 32'(v.exp_we));
    chk($sformatf("v%0d_rd_addr", idx), 32'(o_rd_addr), 32'(v.rd));
    chk($sformatf("v%0d_rd_data", idx), o_rd_data, v.alu);
    chk($sformatf("v%0d_pc", idx), o_pc, exp_pc);
    chk($sformatf("v%0d_opcode", idx), 32'(o_opcode), 32'(v.opcode));
    if (v.chk_load) chk($sformatf("v%0d_data_load", idx), o_load, v.exp_load);
    @(negedge clk);
    chk($sformatf("v%0d_ce_pulse_end", idx), 32'(o_ce), 32'd0);
    chk($sformatf("v%0d_mis_pulse_end", idx), 32'(o_mis), 32'd0);
  endtask

  initial begin
    // opcode, funct, alu, rs2, rdata, rd, ack_after, exp_stb, exp_mis, exp_we, exp_wr,
    // chk_bus, exp_addr, exp_be, exp_wdata, chk_load, exp_load
    vecs[0]  = '{OP_LOAD,  F3_LW,  32'h100, 32'h11223344, 32'hDEADBEEF, 5'd10, 2, 2, 1'b0, 1'b1, 1'b0,
                 1'b0, 32'h100, 4'hF, 32'h0, 1'b1, 32'hDEADBEEF};
    vecs[1]  = '{OP_LOAD,  F3_LB,  32'h103, 32'h0, 32'h80FF1234, 5'd11, 1, 1, 1'b0, 1'b1, 1'b0,
                 1'b0, 32'h100, 4'h8, 32'h0, 1'b1, 32'hFFFFFF80};
    vecs[2]  = '{OP_LOAD,  F3_LBU, 32'h103, 32'h0, 32'h80FF1234, 5'd12, 1, 1, 1'b0, 1'b1, 1'b0,
                 1'b0, 32'h100, 4'h8, 32'h0, 1'b1, 32'h00000080};
    vecs[3]  = '{OP_LOAD,  F3_LH,  32'h102, 32'h0, 32'h80FF1234, 5'd13, 1, 1, 1'b0, 1'b1, 1'b0,
                 1'b0, 32'h100, 4'hC, 32'h0, 1'b1, 32'hFFFF80FF};
    vecs[4]  = '{OP_LOAD,  F3_LHU, 32'h100, 32'h0, 32'h80FF1234, 5'd14, 1, 1, 1'b0, 1'b1, 1'b0,
                 1'b0, 32'h100, 4'h3, 32'h0, 1'b1, 32'h00001234};
    vecs[5]  = '{OP_STORE, F3_SB,  32'h102, 32'h000000AB, 32'h0, 5'd1, 1, 1, 1'b0, 1'b0, 1'b1,
                 1'b1, 32'h100, 4'b0100, 32'hABABABAB, 1'b0, 32'h0};
    vecs[6]  = '{OP_STORE, F3_SH,  32'h102, 32'h0000BEEF, 32'h0, 5'd2, 1, 1, 1'b0, 1'b0, 1'b1,
                 1'b1, 32'h100, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0};
    vecs[7]  = '{OP_STORE, F3_SW,  32'h104, 32'hCAFEF00D, 32'h0, 5'd3, 3, 3, 1'b0, 1'b0, 1'b1,
                 1'b1, 32'h104, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[8]  = '{OP_LOAD,  F3_LW,  32'h102, 32'h0, 32'h0, 5'd4, 1, 0, 1'b1, 1'b0, 1'b0,
                 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
    vecs[9]  = '{OP_STORE, F3_SH,  32'h101, 32'h1234, 32'h0, 5'd5, 1, 0, 1'b1, 1'b0, 1'b0,
                 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
    vecs[10] = '{OP_OP,    3'd0,   32'h55, 32'h0, 32'h0, 5'd3, 1, 0, 1'b0, 1'b1, 1'b0,
                 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
    vecs[11] = '{OP_LOAD,  F3_LB,  32'h101, 32'h0, 32'h80FF1234, 5'd6, 1, 1, 1'b0, 1'b1, 1'b0,
                 1'b0, 32'h100, 4'h2, 32'h0, 1'b1, 32'h00000012};
    vecs[12] = '{OP_STORE, F3_SB,  32'h203, 32'h123456CD, 32'h0, 5'd7, 2, 2, 1'b0, 1'b0, 1'b1,
                 1'b1, 32'h200, 4'b1000, 32'hCDCDCDCD, 1'b0, 32'h0};

    rst = 1'b1; opcode = '0; funct = '0; alu = '0; rs2 = '0; pc = '0; rdata = '0;
    rd = '0; we_rd = 1'b0; ce = 1'b0; stall = 1'b0; flush = 1'b0; ack = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_stb", 32'(o_stb), 32'd0);
    chk("rst_ce", 32'(o_ce), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_addr", o_addr, 32'd0);
    chk("rst_data_load", o_load, 32'd0);
    chk("rst_misaligned", 32'(o_mis), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Stall in IDLE holds every output
    @(negedge clk);
    opcode = OP_OP; funct = 3'd0; alu = 32'h1234; rd = 5'd7; we_rd = 1'b1; ce = 1'b1;
    @(negedge clk);
    chk("alu_rd_data", o_rd_data, 32'h1234);
    alu = 32'h77; stall = 1'b1;
    @(negedge clk);
    chk("stall_out", 32'(o_stall), 32'd1);
    chk("stall_hold_rd_data", o_rd_data, 32'h1234);
    chk("stall_hold_ce", 32'(o_ce), 32'd1);
    @(negedge clk);
    chk("stall_hold_rd_data2", o_rd_data, 32'h1234);
    stall = 1'b0;
    @(negedge clk);
    ce = 1'b0;
    chk("unstall_rd_data", o_rd_data, 32'h77);
    chk("unstall_ce", 32'(o_ce), 32'd1);
    @(negedge clk);
    chk("unstall_ce_end", 32'(o_ce), 32'd0);

    // Flush in IDLE drops the incoming instruction
    alu = 32'h99; ce = 1'b1; flush = 1'b1;
    #1;
    chk("flush_passthru", 32'(o_flush), 32'd1);
    @(negedge clk);
    flush = 1'b0; ce = 1'b0;
    chk("flush_idle_ce", 32'(o_ce), 32'd0);
    chk("flush_idle_rd_data", o_rd_data, 32'h77);

    // Flush in WAIT: bus cycle completes, result is dead
    @(negedge clk);
    opcode = OP_LOAD; funct = F3_LW; alu = 32'h200; rd = 5'd5; we_rd = 1'b1; ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    chk("fw_stb", 32'(o_stb), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fw_stb_kept", 32'(o_stb), 32'd1);
    ack = 1'b1; rdata = 32'h12345678;
    @(negedge clk);
    ack = 1'b0; rdata = '0;
    chk("fw_stb_done", 32'(o_stb), 32'd0);
    chk("fw_ce", 32'(o_ce), 32'd0);
    chk("fw_we_rd", 32'(o_we_rd), 32'd0);
    chk("fw_stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    chk("fw_ce_later", 32'(o_ce), 32'd0);

    // Reset in WAIT clears the bus request at once; a late ack is ignored
    opcode = OP_LOAD; funct = F3_LW; alu = 32'h300; rd = 5'd9; ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    chk("rw_stb", 32'(o_stb), 32'd1);
    chk("rw_stall", 32'(o_stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_stb_async", 32'(o_stb), 32'd0);
    chk("rw_stall_async", 32'(o_stall), 32'd0);
    chk("rw_addr_async", o_addr, 32'd0);
    chk("rw_rd_addr_async", 32'(o_rd_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0; ack = 1'b1; rdata = 32'hFFFFFFFF;
    @(negedge clk);
    ack = 1'b0; rdata = '0;
    chk("rw_late_ack_stb", 32'(o_stb), 32'd0);
    chk("rw_late_ack_ce", 32'(o_ce), 32'd0);
    chk("rw_late_ack_load", o_load, 32'd0);
    chk("rw_late_ack_stall", 32'(o_stall), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL have parameters DWIDTH 32 (data width), AWIDTH 5 (register address width), PC_WIDTH 32 (PC width), FUNCT_WIDTH 3 (funct3 width).
REQ-002 The block SHALL have these ports:
- me_clk  in  1  single clock for the whole block.
- me_rst  in  1  reset, asynchronous, active-high.
- me_i_opcode  in  OPCODE_WIDTH  opcode from execute.
- me_i_funct  in  FUNCT_WIDTH  funct3 from execute.
- me_i_alu_value  in  DWIDTH  ALU result, used as effective address for LOAD/STORE.
- me_i_rs2_data  in  DWIDTH  store data.
- me_i_rd_addr / me_i_we_rd  in  AWIDTH / 1  destination register and its write enable.
- me_i_pc  in  PC_WIDTH  instruction PC.
- me_i_ce / me_i_stall / me_i_flush  in  1  valid from execute, stall from writeback, flush from writeback.
- me_o_stb / me_o_wr_en  out  1  bus request and write qualifier.
- me_o_addr / me_o_wdata  out  DWIDTH  word address (bits 1:0 zero) and lane-replicated store data.
- me_o_byte_en  out  4  byte lane enables.
- me_i_ack / me_i_rdata  in  1 / DWIDTH  bus acknowledge and read word.
- me_o_data_load  out  DWIDTH  aligned, extended load result to writeback.
- me_o_rd_addr / me_o_rd_data / me_o_we_rd  out  AWIDTH / DWIDTH / 1  passthrough to writeback.
- me_o_opcode / me_o_funct / me_o_pc  out  passthrough.
- me_o_ce / me_o_stall / me_o_flush / me_o_misaligned  out  1  result valid, stall to execute, flush to execute, alignment fault.

Function
REQ-003 The block SHALL implement states IDLE and WAIT.
REQ-004 In IDLE with me_i_ce=1, me_i_stall=0, me_i_flush=0, the block SHALL register all passthrough fields on the next edge.
REQ-005 A non-memory opcode SHALL produce me_o_ce=1 for exactly one cycle after capture (latency 1) with me_o_stb=0.
REQ-006 An aligned LOAD/STORE SHALL assert me_o_stb on the cycle after capture, enter WAIT, and hold stb/addr/wdata/byte_en/wr_en stable until me_i_ack.
REQ-007 Ack in WAIT SHALL deassert stb on the next edge, register me_o_data_load (loads only), pulse me_o_ce for one cycle, and return to IDLE; ack in the first stb cycle is legal.
REQ-008 Store lanes SHALL be: SB byte_en=4'b0001<<addr[1:0] with the byte replicated 4x; SH byte_en=4'b0011<<(2*addr[1]) with the halfword replicated 2x; SW byte_en=4'b1111. A store SHALL force me_o_we_rd=0 and me_o_wr_en=1.
REQ-009 Loads SHALL select the lane by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW pass whole word; me_o_wr_en=0.
REQ-010 LH/LHU/SH at an odd address, or LW/SW with addr[1:0]!=0, SHALL issue no bus cycle, pulse me_o_misaligned and me_o_ce for one cycle, and force me_o_we_rd=0.
REQ-011 me_o_stall SHALL equal me_i_stall OR (state==WAIT); me_o_flush SHALL equal me_i_flush.
REQ-012 me_i_stall=1 in IDLE SHALL hold all outputs and accept nothing.
REQ-013 Flush in WAIT SHALL keep stb asserted until ack (no bus abort) but mark the result dead: me_o_ce=0 and me_o_we_rd=0 on completion.
REQ-014 Flush in IDLE SHALL drop the incoming instruction and clear me_o_ce on the next edge.

Reset
REQ-015 Asserting me_rst SHALL immediately force state IDLE and drive all outputs to 0, including mid-WAIT with stb high; a late ack after reset SHALL be ignored.

Structure
REQ-016 OPCODE_WIDTH, the opcode constants (LOAD, STORE, ...) and the funct3 codes (LB..SW) SHALL come from the shared opcode definitions used by all pipeline stages.
REQ-017 The lane/extension logic SHALL be a combinational sub-module mem_align; the FSM and stage registers SHALL stay in memory_access.

Verification
REQ-018 LW addr 0x100, rd=10, ack after 2 stb cycles, rdata 0xDEADBEEF -> stb high 2 cycles, me_o_stall high during WAIT, then data_load=0xDEADBEEF, rd_addr=10, we_rd=1, ce pulses once.
REQ-019 LB addr 0x103, rdata 0x80FF1234 -> data_load 0xFFFFFF80; LBU same address and data -> 0x00000080.
REQ-020 SB addr 0x102, rs2 0x000000AB -> addr 0x100, byte_en 4'b0100, wdata 0xABABABAB, wr_en=1, we_rd=0.
REQ-021 LW addr 0x102 -> stb never asserted, misaligned=1 and ce=1 for one cycle, we_rd=0.
REQ-022 ADD with alu_value 0x55, rd=3 -> next cycle rd_data 0x55, ce=1, stb=0.
REQ-023 Flush in WAIT, then ack -> ce stays 0. Separate run: me_rst asserted in WAIT -> stb=0 immediately, state IDLE.
